// File: rtl/controle_rodada.sv
// Frame-sequencing FSM for the asteroids game: tick wait, movement, collision compare, lives check.
// Optional handshake watchdog enabled by defining CONTROLE_RODADA_WATCHDOG_EN.
module controle_rodada #(
  parameter int unsigned TICK_CICLOS = 50000,
  parameter int unsigned WDT_CICLOS  = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       fim_movimentacao,
  input  logic       fim_comparacao,
  input  logic [1:0] num_vidas,
  output logic       movimenta,
  output logic       compara_tiros_nave_asteroides,
  output logic       jogando,
  output logic       game_over,
  output logic       erro,
  output logic [7:0] rodada,
  output logic [4:0] db_estado
);

  typedef enum logic [3:0] {
    StInicial    = 4'd0,
    StEsperaTick = 4'd1,
    StMovimenta  = 4'd2,
    StEsperaMov  = 4'd3,
    StCompara    = 4'd4,
    StEsperaComp = 4'd5,
    StVerifica   = 4'd6,
    StFimJogo    = 4'd7,
    StErro       = 4'd8
  } estado_e;

  localparam int unsigned TickW = $clog2(TICK_CICLOS);
  localparam logic [TickW-1:0] TickUlt = TickW'(TICK_CICLOS - 1);

`ifdef CONTROLE_RODADA_WATCHDOG_EN
  localparam int unsigned WdtW = (WDT_CICLOS > 2) ? $clog2(WDT_CICLOS) : 1;
  localparam logic [WdtW-1:0] WdtUlt = WdtW'(WDT_CICLOS - 1);
  logic [WdtW-1:0] wdt_q, wdt_d;
  logic            erro_q;
`endif

  estado_e          estado_q, estado_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic [7:0]       rodada_q, rodada_d;
  logic             movimenta_q, compara_q, jogando_q, game_over_q;

  always_comb begin
    estado_d = estado_q;
    tick_d   = tick_q;
    rodada_d = rodada_q;
`ifdef CONTROLE_RODADA_WATCHDOG_EN
    wdt_d    = wdt_q;
`endif
    case (estado_q)
      StInicial, StFimJogo: begin
        if (iniciar) begin
          estado_d = StEsperaTick;
          tick_d   = '0;
          rodada_d = '0;
        end
      end
      StEsperaTick: begin
        if (tick_q == TickUlt) begin
          estado_d = StMovimenta;
          tick_d   = '0;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      StMovimenta: begin
        estado_d = StEsperaMov;
`ifdef CONTROLE_RODADA_WATCHDOG_EN
        wdt_d    = '0;
`endif
      end
      StEsperaMov: begin
        if (fim_movimentacao) begin
          estado_d = StCompara;
        end
`ifdef CONTROLE_RODADA_WATCHDOG_EN
        else if (wdt_q == WdtUlt) begin
          estado_d = StErro;
        end else begin
          wdt_d = wdt_q + 1'b1;
        end
`endif
      end
      StCompara: begin
        estado_d = StEsperaComp;
`ifdef CONTROLE_RODADA_WATCHDOG_EN
        wdt_d    = '0;
`endif
      end
      StEsperaComp: begin
        if (fim_comparacao) begin
          estado_d = StVerifica;
        end
`ifdef CONTROLE_RODADA_WATCHDOG_EN
        else if (wdt_q == WdtUlt) begin
          estado_d = StErro;
        end else begin
          wdt_d = wdt_q + 1'b1;
        end
`endif
      end
      StVerifica: begin
        if (num_vidas == 2'd0) begin
          estado_d = StFimJogo;
        end else begin
          rodada_d = rodada_q + 8'd1;
          estado_d = StEsperaTick;
        end
      end
      StErro: estado_d = StErro;
      default: estado_d = StInicial;
    endcase
  end

  // Outputs are decoded from the next state so they line up with estado_q.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q    <= StInicial;
      tick_q      <= '0;
      rodada_q    <= '0;
      movimenta_q <= 1'b0;
      compara_q   <= 1'b0;
      jogando_q   <= 1'b0;
      game_over_q <= 1'b0;
`ifdef CONTROLE_RODADA_WATCHDOG_EN
      wdt_q       <= '0;
      erro_q      <= 1'b0;
`endif
    end else begin
      estado_q    <= estado_d;
      tick_q      <= tick_d;
      rodada_q    <= rodada_d;
      movimenta_q <= (estado_d == StMovimenta);
      compara_q   <= (estado_d == StCompara);
      jogando_q   <= !(estado_d inside {StInicial, StFimJogo, StErro});
      game_over_q <= (estado_d == StFimJogo);
`ifdef CONTROLE_RODADA_WATCHDOG_EN
      wdt_q       <= wdt_d;
      erro_q      <= (estado_d == StErro);
`endif
    end
  end

  assign movimenta                     = movimenta_q;
  assign compara_tiros_nave_asteroides = compara_q;
  assign jogando                       = jogando_q;
  assign game_over                     = game_over_q;
  assign rodada                        = rodada_q;
  assign db_estado                     = {1'b0, estado_q};
`ifdef CONTROLE_RODADA_WATCHDOG_EN
  assign erro = erro_q;
`else
  assign erro = 1'b0;
`endif

endmodule
